ccx_emem_responder: RTL and testbench
=====================================

Name: ccx_emem_responder

Overview:
- Responder for the core complex external memory bus (emem_*). It sits outside the core complex and terminates its external port.
- Backed by a 64-bit wide on-chip word array. It inserts programmable wait states before grant, performs byte-strobed writes, and returns registered read data and error.
- Used as the external memory model in system builds and as the protocol-checking endpoint in CCX benches.

Parameters:
- AW, 39, address width.
- BASE, 39'h10000000, first byte address served.
- SIZE, 39'h0000FFFF, last served byte offset. Served range is BASE..BASE+SIZE inclusive.
- DEPTH, 8192, number of 64-bit words. Must satisfy DEPTH*8 > SIZE.
- WAIT_CYCLES, 2, stall cycles between request seen and gnt (0..15).
- PROT_SIZE, 39'h0000_0FFF, byte offsets 0..PROT_SIZE are write-protected against user mode (prv==2'b00).
- MEMH, "none", hex init file. "none" means no initialisation.

Ports:
- g_clk, input, 1, free-running clock.
- g_resetn, input, 1, synchronous active-low reset.
- emem_req, input, 1, request valid; held with stable payload until gnt.
- emem_rtype, input, 1, request type (1 = instruction fetch); captured only for trace, no functional effect.
- emem_addr, input, 39, byte address; bits [2:0] ignored.
- emem_wen, input, 1, write enable.
- emem_strb, input, 8, write byte strobes.
- emem_wdata, input, 64, write data.
- emem_prv, input, 2, privilege of request.
- emem_gnt, output, 1, request accepted this cycle.
- emem_err, output, 1, response error; valid from the cycle after gnt.
- emem_rdata, output, 64, read data; valid from the cycle after gnt.
- busy, output, 1, high while in WAIT or GRANT.

Behaviour:
- Reset values: emem_gnt=0, emem_err=0, emem_rdata=0, busy=0, FSM=IDLE, wait counter=0. Array contents are not reset.
- Handshake: a request completes in the cycle where emem_req=1 and emem_gnt=1. emem_rdata and emem_err update on the following rising edge. They hold until the next completed request.
- FSM states: IDLE, WAIT, GRANT.
- IDLE:
  - req=1 and WAIT_CYCLES==0: emem_gnt=1 combinationally in the same cycle; stay IDLE (back-to-back capable).
  - req=1 and WAIT_CYCLES>0: load counter with WAIT_CYCLES-1, go to WAIT.
- WAIT:
  - counter==0: go to GRANT; otherwise decrement.
  - req=0 (request withdrawn): return to IDLE, clear counter, no access performed.
- GRANT:
  - emem_gnt=1 if req=1, and the access is performed.
  - Next state is IDLE, so a new request incurs the full wait.
  - If req=0 in GRANT: no gnt, return to IDLE.
- Latency: gnt arrives WAIT_CYCLES+1 cycles after req rises (WAIT_CYCLES>0); response data one cycle after gnt.
- Address decode: offset = emem_addr - BASE, AW-bit unsigned.
  - Out of range (emem_addr<BASE or offset>SIZE): err=1, rdata=0, no write. Still granted.
  - Word index = offset[3 +: $clog2(DEPTH)].
- Writes: for each strb[i]=1, byte i of the word is updated from wdata[8i+:8].
  - strb=0 with wen=1 is a legal no-op; err=0.
  - Write response: rdata = word value before the write, err=0.
- Protection: wen=1, prv==2'b00 and offset<=PROT_SIZE gives err=1 with no array update. Reads are never protection-faulted.
- Reads: rdata = stored word (full 64 bits, strobes ignored), err=0.
- Reset asserted mid-transaction:
  - FSM to IDLE, outputs to reset values.
  - A write in the GRANT cycle coincident with reset is not performed.

Optional Feature:
- Macro: CCX_EMEM_RESPONDER_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - On entry from IDLE, the wait count is lfsr[3:0] instead of WAIT_CYCLES. A value of 0 grants in the same cycle.
  - All other rules are unchanged.
- Undefined: no LFSR logic; fixed WAIT_CYCLES.

Test Plan:
- Reset: hold g_resetn=0 for 3 cycles with req=1 -> gnt=0, err=0, rdata=0, busy=0 throughout; after release, gnt first rises 3 cycles after req (WAIT_CYCLES=2).
- Write then read: write 0x1000_0008, strb=8'hFF, wdata=64'hDEADBEEF_CAFEF00D, prv=2'b11 -> gnt after 3 cycles, err=0; read same address -> rdata=64'hDEADBEEF_CAFEF00D.
- Partial strobe: write strb=8'h0F, wdata=64'h11111111_22222222 over the above -> read returns 64'hDEADBEEF_22222222.
- Out of range: read 0x1001_0000 -> gnt, err=1, rdata=0; read 0x0FFF_FFF8 -> err=1.
- Protection: user write (prv=2'b00) to 0x1000_0010 -> err=1, later read unchanged; same write to 0x1000_1000 -> err=0, data stored.
- Withdrawal and back-to-back: req dropped after 1 wait cycle -> no gnt, FSM IDLE, memory unchanged. WAIT_CYCLES=0 build, 4 consecutive reads -> gnt=1 on 4 consecutive cycles, rdata streams one cycle behind.

Source files
------------

// File: rtl/ccx_emem_responder.sv
// ccx_emem_responder: emem_* bus endpoint backed by a 64-bit word array with programmable wait states.
// Build option CCX_EMEM_RESPONDER_RANDOM_STALL_EN draws the stall length from a free-running LFSR.
module ccx_emem_responder #(
    parameter int unsigned   AW          = 39,
    parameter logic [AW-1:0] BASE        = 39'h10000000,
    parameter logic [AW-1:0] SIZE        = 39'h0000FFFF,
    parameter int unsigned   DEPTH       = 8192,
    parameter int unsigned   WAIT_CYCLES = 2,
    parameter logic [AW-1:0] PROT_SIZE   = 39'h0000_0FFF,
    parameter                MEMH        = "none"
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          emem_req,
    input  logic          emem_rtype,
    input  logic [AW-1:0] emem_addr,
    input  logic          emem_wen,
    input  logic [7:0]    emem_strb,
    input  logic [63:0]   emem_wdata,
    input  logic [1:0]    emem_prv,
    output logic          emem_gnt,
    output logic          emem_err,
    output logic [63:0]   emem_rdata,
    output logic          busy
);

    localparam int unsigned IW          = $clog2(DEPTH);
    localparam bit          memh_unused = (MEMH == "none");

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          busy_r;
    logic          err_r;
    logic [63:0]   rdata_r;

    logic [AW-1:0] offset_s;
    logic          in_range_s;
    logic          prot_s;
    logic          err_s;
    logic          gnt_s;
    logic          wr_s;
    logic [IW-1:0] idx_s;
    logic [63:0]   word_s;
    logic [3:0]    entry_wait_s;
    logic          unused_s;

    // Word storage; contents survive reset (MEMH preload is applied by the simulation environment).
    logic [63:0]   mem_r [DEPTH];

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef CCX_EMEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall source (taps 16,14,13,11).
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign entry_wait_s = lfsr_r[3:0];
`else
    assign entry_wait_s = 4'(WAIT_CYCLES);
`endif

    // Address decode, range and write-protection checks for the presented request.
    always_comb begin
        offset_s   = emem_addr - BASE;
        in_range_s = (emem_addr >= BASE) && (offset_s <= SIZE);
        idx_s      = offset_s[3 +: IW];
        word_s     = mem_r[idx_s];
        prot_s     = emem_wen && (emem_prv == 2'b00) && (offset_s <= PROT_SIZE);
        err_s      = !in_range_s || prot_s;
    end

    // Grant is combinational on req so zero-wait requests complete back to back.
    always_comb begin
        gnt_s = 1'b0;
        if (!g_resetn) begin
            gnt_s = 1'b0;
        end else if (state_r == ST_GRANT) begin
            gnt_s = emem_req;
        end else if (state_r == ST_IDLE) begin
            gnt_s = emem_req && (entry_wait_s == 4'd0);
        end else begin
            gnt_s = 1'b0;
        end
    end

    assign wr_s     = gnt_s && emem_wen && !err_s;
    assign unused_s = ^{emem_rtype, offset_s, memh_unused};

    // Handshake FSM plus registered response.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (emem_req && (entry_wait_s != 4'd0)) begin
                        cnt_r   <= entry_wait_s - 4'd1;
                        state_r <= ST_WAIT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!emem_req) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= ST_GRANT;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (gnt_s) begin
                err_r   <= err_s;
                rdata_r <= err_s ? 64'd0 : word_s;
            end
        end
    end

    // Byte-strobed array update; gnt_s is already suppressed during reset.
    always_ff @(posedge g_clk) begin
        if (wr_s) begin
            mem_r[idx_s] <= merge_bytes(word_s, emem_wdata, emem_strb);
        end
    end

    assign emem_gnt   = gnt_s;
    assign emem_err   = err_r;
    assign emem_rdata = rdata_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ccx_emem_responder.sv
// Bench for ccx_emem_responder: directed protocol steps plus randomized accesses checked
// against an associative-array memory model; a second zero-wait instance covers streaming.
module tb_ccx_emem_responder;

    localparam logic [38:0] BASE  = 39'h10000000;
    localparam logic [38:0] SIZE  = 39'h0000FFFF;
    localparam logic [38:0] PROT  = 39'h00000FFF;
    localparam int          WAITC = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;

    logic        req_a = 1'b0, rtype_a = 1'b0, wen_a = 1'b0;
    logic [38:0] addr_a = 39'd0;
    logic [7:0]  strb_a = 8'd0;
    logic [63:0] wdata_a = 64'd0;
    logic [1:0]  prv_a = 2'd0;
    logic        gnt_a, err_a, busy_a;
    logic [63:0] rdata_a;

    logic        req_b = 1'b0, rtype_b = 1'b0, wen_b = 1'b0;
    logic [38:0] addr_b = 39'd0;
    logic [7:0]  strb_b = 8'd0;
    logic [63:0] wdata_b = 64'd0;
    logic [1:0]  prv_b = 2'd0;
    logic        gnt_b, err_b, busy_b;
    logic [63:0] rdata_b;

    int errors = 0;
    int checks = 0;
    logic [63:0] model_mem [longint];

    always #5 g_clk = ~g_clk;

    ccx_emem_responder #(.WAIT_CYCLES(WAITC)) dut_a (
        .g_clk(g_clk), .g_resetn(g_resetn), .emem_req(req_a), .emem_rtype(rtype_a),
        .emem_addr(addr_a), .emem_wen(wen_a), .emem_strb(strb_a), .emem_wdata(wdata_a),
        .emem_prv(prv_a), .emem_gnt(gnt_a), .emem_err(err_a), .emem_rdata(rdata_a),
        .busy(busy_a)
    );

    ccx_emem_responder #(.WAIT_CYCLES(0)) dut_b (
        .g_clk(g_clk), .g_resetn(g_resetn), .emem_req(req_b), .emem_rtype(rtype_b),
        .emem_addr(addr_b), .emem_wen(wen_b), .emem_strb(strb_b), .emem_wdata(wdata_b),
        .emem_prv(prv_b), .emem_gnt(gnt_b), .emem_err(err_b), .emem_rdata(rdata_b),
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: range, protection and byte merge straight from the rules.
    task automatic model_access(input logic [38:0] addr, input logic wen, input logic [7:0] strb,
                                input logic [63:0] wdata, input logic [1:0] prv,
                                output logic [63:0] exp_rdata, output logic exp_err,
                                output bit rd_known);
        longint unsigned a, off, idx;
        logic [63:0] w;
        a = longint'(addr);
        exp_rdata = 64'd0;
        exp_err = 1'b0;
        rd_known = 1'b1;
        if (a < longint'(BASE) || (a - longint'(BASE)) > longint'(SIZE)) begin
            exp_err = 1'b1;
        end else begin
            off = a - longint'(BASE);
            idx = off / 8;
            if (wen && prv == 2'b00 && off <= longint'(PROT)) begin
                exp_err = 1'b1;
                rd_known = 1'b0;
            end else begin
                rd_known = model_mem.exists(idx);
                if (rd_known) exp_rdata = model_mem[idx];
                if (wen) begin
                    w = exp_rdata;
                    for (int i = 0; i < 8; i++)
                        if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
                    model_mem[idx] = w;
                end
            end
        end
    endtask

    task automatic wait_gnt_a(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge g_clk);
            if (gnt_a) got = 1'b1;
            else begin
                if (lat == 1) check("busy_in_wait", 64'(busy_a), 64'd1);
                lat++;
            end
            @(posedge g_clk); #1;
        end
    endtask

    task automatic xact_a(input string tag, input logic [38:0] addr, input logic wen,
                          input logic [7:0] strb, input logic [63:0] wdata, input logic [1:0] prv);
        logic [63:0] er;
        logic ee;
        bit known, got;
        int lat;
        model_access(addr, wen, strb, wdata, prv, er, ee, known);
        @(posedge g_clk); #1;
        req_a = 1'b1; addr_a = addr; wen_a = wen; strb_a = strb; wdata_a = wdata; prv_a = prv;
        rtype_a = 1'($urandom_range(0, 1));
        wait_gnt_a(got, lat);
        req_a = 1'b0; wen_a = 1'b0;
        check({tag, "_gnt"}, 64'(got), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(WAITC + 1));
        @(negedge g_clk);
        check({tag, "_err"}, 64'(err_a), 64'(ee));
        if (known) check({tag, "_rdata"}, rdata_a, er);
    endtask

    initial begin
        bit got;
        int lat;
        int n;
        logic [38:0] pool [8];
        logic [63:0] bv [4];

        // Reset held with a pending request.
        req_a = 1'b1; addr_a = 39'h0FFF_FFF8;
        repeat (3) begin
            @(negedge g_clk);
            check("rst_gnt", 64'(gnt_a), 64'd0);
            check("rst_err", 64'(err_a), 64'd0);
            check("rst_rdata", rdata_a, 64'd0);
            check("rst_busy", 64'(busy_a), 64'd0);
        end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        wait_gnt_a(got, lat);
        req_a = 1'b0;
        check("rel_gnt", 64'(got), 64'd1);
        check("rel_lat", 64'(lat), 64'd3);
        @(negedge g_clk);
        check("rel_err", 64'(err_a), 64'd1);
        check("rel_rdata", rdata_a, 64'd0);

        // Directed protocol steps.
        xact_a("wr_full", BASE + 39'h8, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D, 2'b11);
        xact_a("rd_full", BASE + 39'h8, 1'b0, 8'h00, 64'd0, 2'b11);
        check("rd_full_const", rdata_a, 64'hDEADBEEF_CAFEF00D);
        xact_a("wr_part", BASE + 39'h8, 1'b1, 8'h0F, 64'h11111111_22222222, 2'b11);
        xact_a("rd_part", BASE + 39'h8, 1'b0, 8'hFF, 64'd0, 2'b01);
        check("rd_part_const", rdata_a, 64'hDEADBEEF_22222222);
        xact_a("wr_nostrb", BASE + 39'h8, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
        xact_a("rd_nostrb", BASE + 39'h8, 1'b0, 8'h00, 64'd0, 2'b11);
        xact_a("oor_high", 39'h1001_0000, 1'b0, 8'h00, 64'd0, 2'b11);
        xact_a("oor_low", 39'h0FFF_FFF8, 1'b0, 8'h00, 64'd0, 2'b11);
        xact_a("oor_wr", 39'h1001_0000, 1'b1, 8'hFF, 64'h1234, 2'b11);
        xact_a("last_wr", BASE + SIZE - 39'd7, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 2'b11);
        xact_a("last_rd", BASE + SIZE - 39'd7, 1'b0, 8'h00, 64'd0, 2'b11);
        xact_a("prot_init", BASE + 39'h10, 1'b1, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 2'b11);
        xact_a("prot_user", BASE + 39'h10, 1'b1, 8'hFF, 64'h0, 2'b00);
        xact_a("prot_rd", BASE + 39'h10, 1'b0, 8'h00, 64'd0, 2'b00);
        xact_a("unprot_wr", BASE + 39'h1000, 1'b1, 8'hFF, 64'h7777_8888_9999_AAAA, 2'b00);
        xact_a("unprot_rd", BASE + 39'h1000, 1'b0, 8'h00, 64'd0, 2'b00);

        // Withdrawal after one wait cycle: no grant, no write.
        xact_a("wd_init", BASE + 39'h2000, 1'b1, 8'hFF, 64'h0BAD_F00D_0000_0001, 2'b11);
        @(posedge g_clk); #1;
        req_a = 1'b1; addr_a = BASE + 39'h2000; wen_a = 1'b1; strb_a = 8'hFF;
        wdata_a = 64'hFFFF_0000_FFFF_0000; prv_a = 2'b11;
        @(negedge g_clk);
        check("wd_gnt0", 64'(gnt_a), 64'd0);
        @(posedge g_clk); #1;
        @(negedge g_clk);
        check("wd_busy1", 64'(busy_a), 64'd1);
        check("wd_gnt1", 64'(gnt_a), 64'd0);
        @(posedge g_clk); #1;
        req_a = 1'b0;
        @(negedge g_clk);
        check("wd_gnt2", 64'(gnt_a), 64'd0);
        @(posedge g_clk); #1;
        wen_a = 1'b0;
        @(negedge g_clk);
        check("wd_idle", 64'(busy_a), 64'd0);
        xact_a("wd_rd", BASE + 39'h2000, 1'b0, 8'h00, 64'd0, 2'b11);

        // Reset coincident with the granting cycle of a write.
        @(posedge g_clk); #1;
        req_a = 1'b1; addr_a = BASE + 39'h2000; wen_a = 1'b1; strb_a = 8'hFF;
        wdata_a = 64'h5555_5555_5555_5555; prv_a = 2'b11;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge g_clk);
            got = gnt_a;
            n++;
        end
        check("mr_gnt_seen", 64'(got), 64'd1);
        g_resetn = 1'b0;
        #1;
        check("mr_gnt_rst", 64'(gnt_a), 64'd0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1; req_a = 1'b0; wen_a = 1'b0;
        @(negedge g_clk);
        check("mr_err", 64'(err_a), 64'd0);
        check("mr_rdata", rdata_a, 64'd0);
        check("mr_busy", 64'(busy_a), 64'd0);
        xact_a("mr_rd", BASE + 39'h2000, 1'b0, 8'h00, 64'd0, 2'b11);

        // Randomized traffic over a pool including protection and range boundaries.
        pool[0] = BASE + 39'h20;    pool[1] = BASE + 39'h28;   pool[2] = BASE + 39'hFF8;
        pool[3] = BASE + 39'h1000;  pool[4] = BASE + 39'h3000; pool[5] = BASE + 39'hFFF8;
        pool[6] = BASE + 39'h10000; pool[7] = BASE - 39'd8;
        for (int i = 0; i < 6; i++)
            xact_a("rnd_init", pool[i], 1'b1, 8'hFF, {$urandom, $urandom}, 2'b11);
        for (int i = 0; i < 30; i++) begin
            logic [38:0] a;
            a = pool[$urandom_range(0, 7)] | 39'($urandom_range(0, 7));
            xact_a("rnd", a, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
                   2'($urandom_range(0, 3)));
        end

        // Zero-wait instance: back-to-back writes then streamed reads.
        for (int i = 0; i < 4; i++) bv[i] = 64'hB0B0_0000_0F0F_0000 + 64'(i) * 64'h0000_0001_0000_0001;
        for (int i = 0; i < 4; i++) begin
            @(posedge g_clk); #1;
            req_b = 1'b1; wen_b = 1'b1; strb_b = 8'hFF; prv_b = 2'b11;
            addr_b = BASE + 39'h100 + 39'(8 * i); wdata_b = bv[i];
            @(negedge g_clk);
            check("b_wr_gnt", 64'(gnt_b), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge g_clk); #1;
            wen_b = 1'b0;
            if (i < 4) begin
                req_b = 1'b1; addr_b = BASE + 39'h100 + 39'(8 * i);
            end else begin
                req_b = 1'b0;
            end
            @(negedge g_clk);
            if (i < 4) check("b_rd_gnt", 64'(gnt_b), 64'd1);
            else check("b_idle_gnt", 64'(gnt_b), 64'd0);
            if (i >= 1) begin
                check("b_rd_data", rdata_b, bv[i - 1]);
                check("b_rd_err", 64'(err_b), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
